// File: rtl/axil_cfg_sequencer_if.sv
// AXI4-Lite bus bundle for the configuration sequencer.
// master: AW/W/AR channel drivers plus BREADY/RREADY; slave: the mirror.
interface axil_cfg_sequencer_if #(
    parameter int AW = 4,
    parameter int DW = 32
);
    logic [AW-1:0]   AWADDR;
    logic [2:0]      AWPROT;
    logic            AWVALID;
    logic            AWREADY;
    logic [DW-1:0]   WDATA;
    logic [DW/8-1:0] WSTRB;
    logic            WVALID;
    logic            WREADY;
    logic [1:0]      BRESP;
    logic            BVALID;
    logic            BREADY;
    logic [AW-1:0]   ARADDR;
    logic [2:0]      ARPROT;
    logic            ARVALID;
    logic            ARREADY;
    logic [DW-1:0]   RDATA;
    logic [1:0]      RRESP;
    logic            RVALID;
    logic            RREADY;

    modport master (
        output AWADDR, AWPROT, AWVALID,
        input  AWREADY,
        output WDATA, WSTRB, WVALID,
        input  WREADY,
        input  BRESP, BVALID,
        output BREADY,
        output ARADDR, ARPROT, ARVALID,
        input  ARREADY,
        input  RDATA, RRESP, RVALID,
        output RREADY
    );

    modport slave (
        input  AWADDR, AWPROT, AWVALID,
        output AWREADY,
        input  WDATA, WSTRB, WVALID,
        output WREADY,
        output BRESP, BVALID,
        input  BREADY,
        input  ARADDR, ARPROT, ARVALID,
        output ARREADY,
        output RDATA, RRESP, RVALID,
        input  RREADY
    );
endinterface

// File: rtl/axil_cfg_sequencer.sv
// Writes four config registers over AXI4-Lite, reads them back and checks.
// Ports: ACLK/ARESET, start/cfg_data request, busy/done/err status, M_AXI.
module axil_cfg_sequencer #(
    parameter int          C_M_AXI_ADDR_WIDTH = 4,
    parameter int          C_M_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_BASE_ADDR        = 0
) (
    input  logic                         ACLK,
    input  logic                         ARESET,
    input  logic                         start,
    input  logic [127:0]                 cfg_data,
    output logic                         busy,
    output logic                         done,
    output logic [1:0]                   err_code,
    output logic [1:0]                   err_index,
    axil_cfg_sequencer_if.master         M_AXI
);
    localparam int AW = C_M_AXI_ADDR_WIDTH;
    localparam int DW = C_M_AXI_DATA_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_REQ,
        S_WR_RESP,
        S_RD_REQ,
        S_RD_RESP,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      idx_q, idx_d;
    logic            awvalid_q, awvalid_d;
    logic            wvalid_q, wvalid_d;
    logic            arvalid_q, arvalid_d;
    logic [AW-1:0]   awaddr_q, awaddr_d;
    logic [AW-1:0]   araddr_q, araddr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [127:0]    shadow_q, shadow_d;
    logic [1:0]      err_code_q, err_code_d;
    logic [1:0]      err_index_q, err_index_d;
    logic            armed_q, armed_d;
    logic            aw_ok, w_ok;
    logic            fail;
    logic [1:0]      fail_code;

    function automatic logic [AW-1:0] reg_addr(input logic [1:0] i);
        reg_addr = AW'(C_BASE_ADDR) + AW'({i, 2'b00});
    endfunction

    function automatic logic [DW-1:0] reg_word(input logic [127:0] s,
                                               input logic [1:0]   i);
        reg_word = DW'(s[32*i +: 32]);
    endfunction

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        arvalid_d   = arvalid_q;
        awaddr_d    = awaddr_q;
        araddr_d    = araddr_q;
        wdata_d     = wdata_q;
        shadow_d    = shadow_q;
        err_code_d  = err_code_q;
        err_index_d = err_index_q;
        // Becomes 1 on the first edge after reset release, so a start
        // that coincides with that edge is not taken.
        armed_d     = 1'b1;
        aw_ok       = 1'b0;
        w_ok        = 1'b0;
        fail        = 1'b0;
        fail_code   = 2'b00;

        case (state_q)
            S_IDLE: begin
                if (start && armed_q) begin
                    state_d     = S_WR_REQ;
                    idx_d       = 2'd0;
                    shadow_d    = cfg_data;
                    awvalid_d   = 1'b1;
                    wvalid_d    = 1'b1;
                    awaddr_d    = reg_addr(2'd0);
                    wdata_d     = reg_word(cfg_data, 2'd0);
                    err_code_d  = 2'b00;
                    err_index_d = 2'b00;
                end
            end
            S_WR_REQ: begin
                // A channel is finished if it already handshook or does now.
                aw_ok = !awvalid_q || M_AXI.AWREADY;
                w_ok  = !wvalid_q || M_AXI.WREADY;
                if (awvalid_q && M_AXI.AWREADY) begin
                    awvalid_d = 1'b0;
                end
                if (wvalid_q && M_AXI.WREADY) begin
                    wvalid_d = 1'b0;
                end
                if (aw_ok && w_ok) begin
                    state_d = S_WR_RESP;
                end
            end
            S_WR_RESP: begin
                if (M_AXI.BVALID) begin
                    if (M_AXI.BRESP != 2'b00) begin
                        fail      = 1'b1;
                        fail_code = 2'b01;
                    end
                    if (idx_q == 2'd3) begin
                        state_d   = S_RD_REQ;
                        idx_d     = 2'd0;
                        arvalid_d = 1'b1;
                        araddr_d  = reg_addr(2'd0);
                    end else begin
                        state_d   = S_WR_REQ;
                        idx_d     = idx_q + 2'd1;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        awaddr_d  = reg_addr(idx_q + 2'd1);
                        wdata_d   = reg_word(shadow_q, idx_q + 2'd1);
                    end
                end
            end
            S_RD_REQ: begin
                if (arvalid_q && M_AXI.ARREADY) begin
                    arvalid_d = 1'b0;
                    state_d   = S_RD_RESP;
                end
            end
            S_RD_RESP: begin
                if (M_AXI.RVALID) begin
                    // A failed response makes the data meaningless.
                    if (M_AXI.RRESP != 2'b00) begin
                        fail      = 1'b1;
                        fail_code = 2'b10;
                    end else if (M_AXI.RDATA != reg_word(shadow_q, idx_q)) begin
                        fail      = 1'b1;
                        fail_code = 2'b11;
                    end
                    if (idx_q == 2'd3) begin
                        state_d = S_DONE;
                    end else begin
                        state_d   = S_RD_REQ;
                        idx_d     = idx_q + 2'd1;
                        arvalid_d = 1'b1;
                        araddr_d  = reg_addr(idx_q + 2'd1);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Only the first failure of a run is kept.
        if (fail && err_code_q == 2'b00) begin
            err_code_d  = fail_code;
            err_index_d = idx_q;
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q     <= S_IDLE;
            idx_q       <= 2'd0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            awaddr_q    <= '0;
            araddr_q    <= '0;
            wdata_q     <= '0;
            shadow_q    <= '0;
            err_code_q  <= 2'b00;
            err_index_q <= 2'b00;
            armed_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            arvalid_q   <= arvalid_d;
            awaddr_q    <= awaddr_d;
            araddr_q    <= araddr_d;
            wdata_q     <= wdata_d;
            shadow_q    <= shadow_d;
            err_code_q  <= err_code_d;
            err_index_q <= err_index_d;
            armed_q     <= armed_d;
        end
    end

    assign M_AXI.AWADDR  = awaddr_q;
    assign M_AXI.AWPROT  = 3'b000;
    assign M_AXI.AWVALID = awvalid_q;
    assign M_AXI.WDATA   = wdata_q;
    assign M_AXI.WSTRB   = '1;
    assign M_AXI.WVALID  = wvalid_q;
    assign M_AXI.BREADY  = (state_q == S_WR_RESP);
    assign M_AXI.ARADDR  = araddr_q;
    assign M_AXI.ARPROT  = 3'b000;
    assign M_AXI.ARVALID = arvalid_q;
    assign M_AXI.RREADY  = (state_q == S_RD_RESP);

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign err_code  = err_code_q;
    assign err_index = err_index_q;
endmodule
